// File: rtl/condicionador_controle_drone.sv
// condicionador_controle_drone
//   Conditions the raw left/right/confirm push-buttons into clean synchronous
//   commands for the drone simulator top level.
//   Ports:
//     clock          : system clock, rising edge
//     reset          : synchronous, active-high, clears all state
//     botao_esquerda : raw left button (async, bouncy)
//     botao_direita  : raw right button (async, bouncy)
//     botao_confirma : raw confirm button (async, bouncy)
//     controle[1:0]  : debounced direction level (00 none/both, 01 left, 10 right)
//     controle_pulso : one-cycle move strobe, with hold-to-repeat
//     confirma       : one-cycle strobe on confirm press
//     db_estado[3:0] : repeat FSM state (0 OCIOSO, 1 ESPERA, 2 REPETE)

// Per-button 2-flop synchronizer plus debouncer. est_nxt is exposed so the
// parent can register strobes on the same edge the stable level changes.
module condicionador_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic botao,
    output logic est,
    output logic est_nxt
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          est_q, est_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d  = botao;
        s2_d  = s1_q;
        est_d = est_q;
        cnt_d = '0;
        // Any sample matching est leaves cnt at zero, so a glitch restarts the count.
        if (s2_q != est_q) begin
            if (cnt_q == CNT_MAX) begin
                est_d = ~est_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            est_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            est_q <= est_d;
            cnt_q <= cnt_d;
        end
    end

    assign est     = est_q;
    assign est_nxt = est_d;
endmodule

module condicionador_controle_drone #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 2000,
    parameter int REPEAT_PERIOD   = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       botao_esquerda,
    input  logic       botao_direita,
    input  logic       botao_confirma,
    output logic [1:0] controle,
    output logic       controle_pulso,
    output logic       confirma,
    output logic [3:0] db_estado
);
    localparam int NUM_BTN = 3;
    localparam int BTN_ESQ = 0;
    localparam int BTN_DIR = 1;
    localparam int BTN_CNF = 2;

    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(TMAX);
    localparam logic [TW-1:0] DELAY_M1  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_M1 = TW'(REPEAT_PERIOD - 1);

    localparam logic [1:0] OCIOSO = 2'd0;
    localparam logic [1:0] ESPERA = 2'd1;
    localparam logic [1:0] REPETE = 2'd2;

    logic [NUM_BTN-1:0] raw, est, est_nxt;

    assign raw = {botao_confirma, botao_direita, botao_esquerda};

    condicionador_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db [NUM_BTN-1:0] (
        .clock   (clock),
        .reset   (reset),
        .botao   (raw),
        .est     (est),
        .est_nxt (est_nxt)
    );

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    controle_q, controle_d;
    logic          pulso_q, pulso_d;
    logic          confirma_q, confirma_d;
    logic [1:0]    code_atual;

    // Both buttons pressed decodes to 00, i.e. treated as a release.
    always_comb begin
        controle_d = (est_nxt[BTN_ESQ] ^ est_nxt[BTN_DIR]) ? {est_nxt[BTN_DIR], est_nxt[BTN_ESQ]} : 2'b00;
        code_atual = (est[BTN_ESQ] ^ est[BTN_DIR]) ? {est[BTN_DIR], est[BTN_ESQ]} : 2'b00;
        confirma_d = est_nxt[BTN_CNF] & ~est[BTN_CNF];
    end

    // The FSM looks at the next code so its strobe lands on the same edge
    // as the debounced level change. Code change wins over timer expiry.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pulso_d = 1'b0;
        case (state_q)
            OCIOSO: begin
                if (controle_d != 2'b00) begin
                    pulso_d = 1'b1;
                    timer_d = '0;
                    state_d = ESPERA;
                end
            end
            ESPERA: begin
                if (controle_d == 2'b00) begin
                    state_d = OCIOSO;
                end else if (controle_d != code_atual) begin
                    pulso_d = 1'b1;
                    timer_d = '0;
                end else if (timer_q == DELAY_M1) begin
                    pulso_d = 1'b1;
                    timer_d = '0;
                    state_d = REPETE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            REPETE: begin
                if (controle_d == 2'b00) begin
                    state_d = OCIOSO;
                end else if (controle_d != code_atual) begin
                    pulso_d = 1'b1;
                    timer_d = '0;
                    state_d = ESPERA;
                end else if (timer_q == PERIOD_M1) begin
                    pulso_d = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = OCIOSO;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= OCIOSO;
            timer_q    <= '0;
            controle_q <= 2'b00;
            pulso_q    <= 1'b0;
            confirma_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            controle_q <= controle_d;
            pulso_q    <= pulso_d;
            confirma_q <= confirma_d;
        end
    end

    assign controle       = controle_q;
    assign controle_pulso = pulso_q;
    assign confirma       = confirma_q;
    assign db_estado      = {2'b00, state_q};
endmodule

// File: tb/tb_condicionador_controle_drone.sv
module tb_condicionador_controle_drone;
    logic       clock = 1'b0;
    logic       reset;
    logic       botao_esquerda, botao_direita, botao_confirma;
    logic [1:0] controle;
    logic       controle_pulso, confirma;
    logic [3:0] db_estado;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        logic       p;
        logic       c;
        logic [1:0] ctl;
        logic [3:0] st;
    } ev_t;

    ev_t q[$];
    ev_t mon_e;

    condicionador_controle_drone #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20),
        .REPEAT_PERIOD(8)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .botao_esquerda (botao_esquerda),
        .botao_direita  (botao_direita),
        .botao_confirma (botao_confirma),
        .controle       (controle),
        .controle_pulso (controle_pulso),
        .confirma       (confirma),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every strobe must match the head of the expected queue.
    always @(posedge clock) begin
        #1;
        if (controle_pulso || confirma) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL strobe_unexpected cyc=%0d got pulso=%0b confirma=%0b ctl=%b st=%0d, required no strobe",
                         cyc, controle_pulso, confirma, controle, db_estado);
            end else begin
                mon_e = q.pop_front();
                if (mon_e.cyc != cyc || mon_e.p !== controle_pulso || mon_e.c !== confirma ||
                    mon_e.ctl !== controle || mon_e.st !== db_estado) begin
                    bad++;
                    $display("FAIL strobe got cyc=%0d p=%0b c=%0b ctl=%b st=%0d required cyc=%0d p=%0b c=%0b ctl=%b st=%0d",
                             cyc, controle_pulso, confirma, controle, db_estado,
                             mon_e.cyc, mon_e.p, mon_e.c, mon_e.ctl, mon_e.st);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic push(input int c, input logic p, input logic f, input logic [1:0] ctl, input logic [3:0] st);
        ev_t e;
        e.cyc = c; e.p = p; e.c = f; e.ctl = ctl; e.st = st;
        q.push_back(e);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_controle"}, int'(controle), 0);
        chk({nm, "_estado"}, int'(db_estado), 0);
    endtask

    int t;

    initial begin
        reset = 1'b1;
        botao_esquerda = 1'b0;
        botao_direita  = 1'b0;
        botao_confirma = 1'b0;
        tick(2);
        chk("rst_controle", int'(controle), 0);
        chk("rst_pulso", int'(controle_pulso), 0);
        chk("rst_confirma", int'(confirma), 0);
        chk("rst_estado", int'(db_estado), 0);
        reset = 1'b0;

        // 1: quiet inputs
        tick(20);
        chk_idle("quiet");
        chk("quiet_pulso", int'(controle_pulso), 0);

        // 2: bouncing left button never settles
        for (int i = 0; i < 12; i++) begin
            botao_esquerda = ~botao_esquerda;
            tick(1);
        end
        botao_esquerda = 1'b0;
        tick(10);
        chk_idle("bounce");

        // 3: clean left press of 10 cycles
        t = cyc;
        botao_esquerda = 1'b1;
        push(t + 6, 1'b1, 1'b0, 2'b01, 4'd1);
        tick(10);
        chk("left_controle", int'(controle), 1);
        chk("left_estado", int'(db_estado), 1);
        botao_esquerda = 1'b0;
        tick(10);
        chk_idle("left_rel");

        // 4: right held 56 cycles with auto-repeat
        t = cyc;
        botao_direita = 1'b1;
        push(t + 6,  1'b1, 1'b0, 2'b10, 4'd1);
        push(t + 26, 1'b1, 1'b0, 2'b10, 4'd2);
        push(t + 34, 1'b1, 1'b0, 2'b10, 4'd2);
        push(t + 42, 1'b1, 1'b0, 2'b10, 4'd2);
        push(t + 50, 1'b1, 1'b0, 2'b10, 4'd2);
        push(t + 58, 1'b1, 1'b0, 2'b10, 4'd2);
        tick(56);
        botao_direita = 1'b0;
        tick(5);
        chk("rep_controle", int'(controle), 2);
        chk("rep_estado", int'(db_estado), 2);
        tick(1);
        chk_idle("rep_rel");
        tick(10);

        // 5: both held reads as release, then right alone is a fresh press
        t = cyc;
        botao_esquerda = 1'b1;
        push(t + 6, 1'b1, 1'b0, 2'b01, 4'd1);
        tick(3);
        botao_direita = 1'b1;
        tick(8);
        chk_idle("both");
        botao_esquerda = 1'b0;
        push(t + 17, 1'b1, 1'b0, 2'b10, 4'd1);
        tick(10);
        chk("only_r_controle", int'(controle), 2);
        chk("only_r_estado", int'(db_estado), 1);
        botao_direita = 1'b0;
        tick(10);
        chk_idle("both_rel");

        // 6: confirm held, reset in the middle gives exactly one more strobe
        t = cyc;
        botao_confirma = 1'b1;
        push(t + 6, 1'b0, 1'b1, 2'b00, 4'd0);
        tick(50);
        reset = 1'b1;
        tick(1);
        chk("mid_rst_confirma", int'(confirma), 0);
        chk_idle("mid_rst");
        reset = 1'b0;
        push(t + 57, 1'b0, 1'b1, 2'b00, 4'd0);
        tick(50);
        botao_confirma = 1'b0;
        tick(10);
        chk_idle("conf_end");

        // expected strobes that never appeared
        while (q.size() > 0) begin
            mon_e = q.pop_front();
            total++;
            bad++;
            $display("FAIL strobe_missing got=none required cyc=%0d p=%0b c=%0b ctl=%b st=%0d",
                     mon_e.cyc, mon_e.p, mon_e.c, mon_e.ctl, mon_e.st);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
